mem_lsu: RTL
============

Name: mem_lsu

Overview:
Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs and performs the data-memory access over a req/ack bus. It stalls the pipeline while an access is outstanding, then presents registered write-back results to the MEM/WB stage. Non-memory instructions pass through with one cycle of latency.

Parameters:
DATA_W, 32, data bus and register width
ADDR_W, 32, byte address width
REG_ADDR_W, 5, register-file address width
MAX_WAIT, 255, bus cycles to wait for ack before declaring a bus error (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
mem_valid  in  1  EX/MEM holds a live instruction
mem_op  in  4  0 NOP/ALU, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NOP
mem_wd_addr  in  REG_ADDR_W  destination register
mem_wreg  in  1  register write enable
mem_wdata  in  DATA_W  ALU result (passes through for non-loads)
mem_addr  in  ADDR_W  effective byte address
mem_sdata  in  DATA_W  store data, right-aligned
bus_req  out  1  access request
bus_we  out  1  1 = store
bus_addr  out  ADDR_W  word-aligned address {mem_addr[ADDR_W-1:2],2'b00}
bus_sel  out  4  byte lanes; bit3 = bits 31:24
bus_wdata  out  DATA_W  lane-replicated store data
bus_ack  in  1  one-cycle completion strobe
bus_rdata  in  DATA_W  read data, valid with ack
stall_req  out  1  hold EX/MEM and earlier stages
wb_wd_addr  out  REG_ADDR_W  registered to MEM/WB
wb_wreg  out  1  registered write enable
wb_wdata  out  DATA_W  registered write data
align_err  out  1  one-cycle pulse: misaligned access
bus_err  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset: state IDLE; all outputs 0; wait counter 0. A reset during ACCESS drops bus_req at that edge and abandons the access. No write-back occurs.
- Memory ops are mem_valid with mem_op 1..8. Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
- IDLE:
  - Non-memory op, or !mem_valid: at the next edge wb_* <= mem_* (wb_wreg <= mem_wreg & mem_valid). stall_req = 0.
  - Misaligned memory op: no bus access. Next edge: wb_wreg <= 0, align_err <= 1 for one cycle. stall_req = 0.
  - Aligned memory op: stall_req = 1 (combinational). Next edge: latch op, wd_addr, wreg and byte offset; drive bus_* registered; enter ACCESS.
- ACCESS:
  - bus_req = 1. bus_we, bus_addr, bus_sel and bus_wdata are held stable until ack or timeout.
  - stall_req = !bus_ack.
  - On bus_ack: next edge bus_req <= 0, state IDLE. Load: wb_wdata <= extracted data, wb_wreg <= latched wreg. Store: wb_wreg <= 0. The EX/MEM register advances at the same edge.
  - Wait counter increments each cycle without ack. When it reaches MAX_WAIT: next edge bus_req <= 0, bus_err pulse, wb_wreg <= 0, state IDLE, stall_req = 0 in that cycle. Ack and timeout in the same cycle: ack wins.
- Lane mapping is big-endian. Byte offset 0 → sel 4'b1000 and bits 31:24. Halfword offset 0 → 4'b1100; offset 2 → 4'b0011. Word → 4'b1111.
- Store data: byte is replicated into all four lanes; half into both halves.
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend; LW is bus_rdata unchanged.
- Latency: pass-through 1 cycle. Load/store ≥ 2 cycles (1 issue + ack wait).

Decomposition:
- Shared defines: mem_op encodings, lane-select constants, LSU state encodings, and the existing RstEnable/ZeroWord/NOPRegAddr constants.
- One sub-module, lsu_align: combinational offset→sel, store replication, and load extract/extend. This sub-module is reused by a future instruction-fetch or cache path.

Test Plan:
- ALU pass-through: mem_op=0, wd_addr=3, wreg=1, wdata=0x12345678 → next cycle wb_* match, stall_req=0, bus_req never asserted.
- LB: addr=0x101, rdata=0x11F23344, ack after 3 cycles → bus_addr=0x100, sel=0100, stall_req high 4 cycles, wb_wdata=0xFFFFFFF2.
- SH: addr=0x202, sdata=0x0000ABCD, ack immediate → bus_we=1, sel=0011, bus_wdata=0xABCDABCD, wb_wreg=0.
- LW at addr=0x103 → align_err one-cycle pulse, no bus_req, wb_wreg=0, stall_req=0.
- MAX_WAIT=4, LW with no ack → bus_req high 4 cycles then low, bus_err pulse, stall released.
- rst asserted during ACCESS → next edge bus_req=0, all outputs 0; a later ack is ignored.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: op encodings,
// byte-lane selects, LSU state encodings and legacy pipeline constants.
package mem_lsu_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    // Big-endian lanes: offset 0 is the most significant byte.
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_B0   = 4'b1000;
    localparam logic [3:0] SEL_B1   = 4'b0100;
    localparam logic [3:0] SEL_B2   = 4'b0010;
    localparam logic [3:0] SEL_B3   = 4'b0001;
    localparam logic [3:0] SEL_H0   = 4'b1100;
    localparam logic [3:0] SEL_H2   = 4'b0011;
    localparam logic [3:0] SEL_W    = 4'b1111;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return off != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: offset to lane select, store-data
// replication and load extraction with sign/zero extension.
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] sdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        sel,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ldata
);

    logic signed [7:0]  byte_p0;
    logic signed [15:0] half_p0;

    function automatic logic [DATA_W-1:0] ext8(input logic signed [7:0] b, input logic sgn);
        return sgn ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] ext16(input logic signed [15:0] h, input logic sgn);
        return sgn ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
    endfunction

    always_comb begin
        case (off)
            2'd0:    byte_p0 = rdata[31:24];
            2'd1:    byte_p0 = rdata[23:16];
            2'd2:    byte_p0 = rdata[15:8];
            default: byte_p0 = rdata[7:0];
        endcase
        half_p0 = off[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        sel   = SEL_NONE;
        wdata = sdata;
        ldata = rdata;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                case (off)
                    2'd0:    sel = SEL_B0;
                    2'd1:    sel = SEL_B1;
                    2'd2:    sel = SEL_B2;
                    default: sel = SEL_B3;
                endcase
                wdata = {4{sdata[7:0]}};
                ldata = ext8(byte_p0, op == OP_LB);
            end
            OP_LH, OP_LHU, OP_SH: begin
                sel   = off[1] ? SEL_H2 : SEL_H0;
                wdata = {2{sdata[15:0]}};
                ldata = ext16(half_p0, op == OP_LH);
            end
            OP_LW, OP_SW: sel = SEL_W;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one data-memory access per memory op
// over a req/ack bus, stalls upstream while it waits, registers write-back.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [3:0]            mem_op,
    input  logic [REG_ADDR_W-1:0] mem_wd_addr,
    input  logic                  mem_wreg,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_sdata,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  stall_req,
    output logic [REG_ADDR_W-1:0] wb_wd_addr,
    output logic                  wb_wreg,
    output logic [DATA_W-1:0]     wb_wdata,
    output logic                  align_err,
    output logic                  bus_err
);

    logic [0:0]            state;
    logic [7:0]            wait_cnt;
    logic [3:0]            op_p1;
    logic [1:0]            off_p1;
    logic                  wreg_p1;
    logic [REG_ADDR_W-1:0] wd_addr_p1;

    logic            is_mem_p0, misal_p0, issue_p0, in_access, timeout;
    logic [3:0]      align_op;
    logic [1:0]      align_off;
    logic [3:0]      align_sel;
    logic [DATA_W-1:0] align_wdata, align_ldata;

    assign in_access = (state == ST_ACCESS);
    assign is_mem_p0 = mem_valid && op_is_mem(mem_op);
    assign misal_p0  = is_mem_p0 && op_misaligned(mem_op, mem_addr[1:0]);
    assign issue_p0  = !in_access && is_mem_p0 && !misal_p0;
    // Ack in the final wait cycle still completes the access.
    assign timeout   = in_access && !bus_ack && (wait_cnt == 8'(MAX_WAIT - 1));
    assign stall_req = issue_p0 || (in_access && !bus_ack && !timeout);

    // Issue steers lanes from the live op; completion extracts with the latched op.
    assign align_op  = in_access ? op_p1  : mem_op;
    assign align_off = in_access ? off_p1 : mem_addr[1:0];

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .op    (align_op),
        .off   (align_off),
        .sdata (mem_sdata),
        .rdata (bus_rdata),
        .sel   (align_sel),
        .wdata (align_wdata),
        .ldata (align_ldata)
    );

    // Stage p1: instruction fields held for the duration of the access
    always_ff @(posedge clk) begin
        if (issue_p0) begin
            op_p1      <= mem_op;
            off_p1     <= mem_addr[1:0];
            wreg_p1    <= mem_wreg;
            wd_addr_p1 <= mem_wd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= ST_IDLE;
            wait_cnt   <= 8'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_sel    <= SEL_NONE;
            bus_wdata  <= ZeroWord;
            wb_wd_addr <= NOPRegAddr;
            wb_wreg    <= 1'b0;
            wb_wdata   <= ZeroWord;
            align_err  <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            if (!in_access) begin
                if (issue_p0) begin
                    state     <= ST_ACCESS;
                    wait_cnt  <= 8'd0;
                    bus_req   <= 1'b1;
                    bus_we    <= op_is_store(mem_op);
                    bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                    bus_sel   <= align_sel;
                    bus_wdata <= align_wdata;
                    wb_wreg   <= 1'b0;
                end else if (misal_p0) begin
                    wb_wreg   <= 1'b0;
                    align_err <= 1'b1;
                end else begin
                    wb_wd_addr <= mem_wd_addr;
                    wb_wreg    <= mem_wreg & mem_valid;
                    wb_wdata   <= mem_wdata;
                end
            end else if (bus_ack) begin
                state    <= ST_IDLE;
                wait_cnt <= 8'd0;
                bus_req  <= 1'b0;
                bus_we   <= 1'b0;
                if (op_is_load(op_p1)) begin
                    wb_wd_addr <= wd_addr_p1;
                    wb_wreg    <= wreg_p1;
                    wb_wdata   <= align_ldata;
                end else begin
                    wb_wreg <= 1'b0;
                end
            end else if (timeout) begin
                state    <= ST_IDLE;
                wait_cnt <= 8'd0;
                bus_req  <= 1'b0;
                bus_we   <= 1'b0;
                bus_err  <= 1'b1;
                wb_wreg  <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
                wb_wreg  <= 1'b0;
            end
        end
    end

endmodule
